dbuf_drive_seq: RTL and testbench

Non-overlap drive sequencer for the step-down power stage's high-side and low-side digital buffers. It converts the loop PWM command into two registered buffer inputs with programmable dead time, diode-emulation low-side cutoff, latched fault shutdown and optional minimum on-time. It sits in the loop control between the PWM modulator and the gate-driver buffers.

---
 rtl/dbuf_drv_pkg.sv | 15 +
 rtl/dbuf_drv_dtcnt.sv | 30 +++
 rtl/dbuf_drive_seq.sv | 137 +++++++++++++
 tb/tb_dbuf_drive_seq.sv | 192 +++++++++++++++++++
 4 files changed

// File: rtl/dbuf_drv_pkg.sv
// Shared types and constants for the dbuf_drive_seq non-overlap drive sequencer.
package dbuf_drv_pkg;

    localparam int DTW_DEF = 6;
    localparam int DT_MIN  = 1;

    typedef enum logic [2:0] {
        OFF,
        DT_LH,
        HS_ON,
        DT_HL,
        LS_ON
    } dbuf_drv_state_t;

endpackage

// File: rtl/dbuf_drv_dtcnt.sv
// Loadable dead-time down-counter; a zero load is clamped to DT_MIN, `last` flags count == 1.
module dbuf_drv_dtcnt
    import dbuf_drv_pkg::*;
#(
    parameter int DTW = DTW_DEF
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           load,
    input  logic [DTW-1:0] value,
    input  logic           dec,
    output logic           last
);

    logic [DTW-1:0] cnt;

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= (value == '0) ? DTW'(DT_MIN) : value;
        end else if (dec && cnt != '0) begin
            cnt <= cnt - 1'b1;
        end
    end

    assign last = (cnt == DTW'(DT_MIN));

endmodule

// File: rtl/dbuf_drive_seq.sv
// Non-overlap high/low-side buffer drive sequencer with dead time, diode emulation and fault latch.
// Optional minimum high-side on-time is built when DBUF_DRV_MINON_EN is defined.
module dbuf_drive_seq
    import dbuf_drv_pkg::*;
#(
    parameter int DTW   = DTW_DEF,
    parameter int MINON = 8,
    parameter int MOW   = 4
) (
    input  logic           CELCLK,
    input  logic           CELRSTN,
    input  logic           CELV,
    input  logic           CELG,
    input  logic           SUB,
    input  logic           en,
    input  logic           pwm,
    input  logic           zcd,
    input  logic           flt,
    input  logic [DTW-1:0] dt_lh,
    input  logic [DTW-1:0] dt_hl,
    output logic           hs_o,
    output logic           ls_o,
    output logic           flt_lat
);

    dbuf_drv_state_t state, state_nxt;
    logic            dt_load;
    logic [DTW-1:0]  dt_val;
    logic            dt_dec;
    logic            dt_last;
    logic            hs_release;

    // Supply pins exist only for the cell generator.
    logic unused_pins;
    assign unused_pins = ^{CELV, CELG, SUB, 1'b0};

    dbuf_drv_dtcnt #(.DTW(DTW)) u_dtcnt (
        .clk   (CELCLK),
        .rst_n (CELRSTN),
        .load  (dt_load),
        .value (dt_val),
        .dec   (dt_dec),
        .last  (dt_last)
    );

    assign dt_dec = (state == DT_LH) || (state == DT_HL);

`ifdef DBUF_DRV_MINON_EN
    logic [MOW-1:0] mo_cnt;

    // Held at zero outside HS_ON, so it starts from zero on every HS_ON entry.
    always_ff @(posedge CELCLK or negedge CELRSTN) begin
        if (!CELRSTN) begin
            mo_cnt <= '0;
        end else if (state != HS_ON) begin
            mo_cnt <= '0;
        end else if (mo_cnt != MOW'(MINON)) begin
            mo_cnt <= mo_cnt + 1'b1;
        end
    end

    assign hs_release = (mo_cnt >= MOW'(MINON - 1));
`else
    logic unused_minon;
    assign unused_minon = (MINON > MOW);
    assign hs_release   = 1'b1;
`endif

    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        state_nxt = state;
        dt_load   = 1'b0;
        dt_val    = dt_lh;
        if (flt || !en) begin
            state_nxt = OFF;
        end else begin
            case (state)
                OFF: begin
                    if (!flt_lat && pwm) begin
                        state_nxt = DT_LH;
                        dt_load   = 1'b1;
                    end
                end
                DT_LH: begin
                    if (dt_last) begin
                        state_nxt = HS_ON;
                    end else if (!pwm) begin
                        state_nxt = DT_HL;
                        dt_load   = 1'b1;
                        dt_val    = dt_hl;
                    end
                end
                HS_ON: begin
                    if (!pwm && hs_release) begin
                        state_nxt = DT_HL;
                        dt_load   = 1'b1;
                        dt_val    = dt_hl;
                    end
                end
                DT_HL: begin
                    if (dt_last) begin
                        state_nxt = LS_ON;
                    end
                end
                LS_ON: begin
                    if (pwm) begin
                        state_nxt = DT_LH;
                        dt_load   = 1'b1;
                    end else if (zcd) begin
                        state_nxt = OFF;
                    end
                end
                default: state_nxt = OFF;
            endcase
        end
    end

    // Outputs decode the next state so they change on the same edge as the state register.
    always_ff @(posedge CELCLK or negedge CELRSTN) begin
        if (!CELRSTN) begin
            state   <= OFF;
            hs_o    <= 1'b0;
            ls_o    <= 1'b0;
            flt_lat <= 1'b0;
        end else begin
            state <= state_nxt;
            hs_o  <= (state_nxt == HS_ON);
            ls_o  <= (state_nxt == LS_ON);
            if (!en) begin
                flt_lat <= 1'b0;
            end else if (flt) begin
                flt_lat <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_dbuf_drive_seq.sv
// Self-checking bench for dbuf_drive_seq: per-cycle vector table with a scoreboard queue,
// plus hand sequences for minimum on-time and asynchronous reset.
module tb_dbuf_drive_seq;

    localparam int DTW = 6;
`ifdef DBUF_DRV_MINON_EN
    localparam int EXP_HS_WIDTH = 8;
`else
    localparam int EXP_HS_WIDTH = 2;
`endif

    logic           clk = 1'b0;
    logic           rst_n;
    logic           en, pwm, zcd, flt;
    logic [DTW-1:0] dt_lh, dt_hl;
    logic           hs_o, ls_o, flt_lat;

    dbuf_drive_seq #(.DTW(DTW), .MINON(8), .MOW(4)) dut (
        .CELCLK  (clk),
        .CELRSTN (rst_n),
        .CELV    (1'b1),
        .CELG    (1'b0),
        .SUB     (1'b0),
        .en      (en),
        .pwm     (pwm),
        .zcd     (zcd),
        .flt     (flt),
        .dt_lh   (dt_lh),
        .dt_hl   (dt_hl),
        .hs_o    (hs_o),
        .ls_o    (ls_o),
        .flt_lat (flt_lat)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic           en, pwm, zcd, flt;
        logic [DTW-1:0] lh, hl;
        logic           hs, ls, fl;
    } vec_t;

    typedef struct {
        logic hs, ls, fl;
    } exp_t;

    vec_t vecs[$];
    exp_t sb[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    function automatic void add(input logic e, input logic p, input logic z, input logic f,
                                input int lh, input int hl,
                                input logic hs, input logic ls, input logic fl);
        vec_t v;
        v.en = e; v.pwm = p; v.zcd = z; v.flt = f;
        v.lh = DTW'(lh); v.hl = DTW'(hl);
        v.hs = hs; v.ls = ls; v.fl = fl;
        vecs.push_back(v);
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        exp_t e;
        int   hs_cnt;

        //   en pwm zcd flt lh hl   hs ls fl   (outputs after the edge sampling the row)
        add(1, 0, 0, 0, 3, 2,  0, 0, 0);  // idle in OFF
        add(1, 1, 0, 0, 3, 2,  0, 0, 0);  // OFF -> DT_LH, 3 dead cycles
        add(1, 1, 0, 0, 3, 2,  0, 0, 0);
        add(1, 1, 0, 0, 3, 2,  0, 0, 0);
        add(1, 1, 0, 0, 3, 2,  1, 0, 0);  // HS_ON 3 edges after pwm sampled
        add(1, 1, 0, 0, 3, 2,  1, 0, 0);
        add(1, 0, 0, 0, 3, 2,  0, 0, 0);  // hs falls after 1 edge
        add(1, 0, 0, 0, 3, 2,  0, 0, 0);
        add(1, 0, 0, 0, 3, 2,  0, 1, 0);  // ls rises 2 edges later
        add(1, 0, 0, 0, 3, 2,  0, 1, 0);
        add(1, 1, 0, 0, 3, 2,  0, 0, 0);  // LS_ON -> DT_LH
        add(1, 1, 0, 0, 3, 2,  0, 0, 0);
        add(1, 1, 0, 0, 3, 2,  0, 0, 0);
        add(1, 1, 0, 0, 3, 2,  1, 0, 0);
        add(1, 0, 0, 0, 3, 2,  0, 0, 0);  // HS_ON -> DT_HL
        add(1, 1, 0, 0, 3, 2,  0, 0, 0);  // pwm rise does not shorten DT_HL
        add(1, 0, 0, 0, 3, 2,  0, 1, 0);
        add(1, 0, 1, 0, 3, 2,  0, 0, 0);  // zcd ends low side
        add(1, 0, 0, 0, 3, 2,  0, 0, 0);  // stays OFF
        add(1, 1, 0, 0, 0, 0,  0, 0, 0);  // zero dead time clamps to 1
        add(1, 1, 0, 0, 0, 0,  1, 0, 0);
        add(1, 0, 0, 0, 0, 0,  0, 0, 0);
        add(1, 0, 0, 0, 0, 0,  0, 1, 0);
        add(1, 1, 1, 0, 0, 0,  0, 0, 0);  // pwm beats zcd -> DT_LH
        add(1, 1, 1, 0, 0, 0,  1, 0, 0);
        add(1, 1, 0, 1, 0, 0,  0, 0, 1);  // fault during HS_ON
        add(1, 1, 0, 0, 0, 0,  0, 0, 1);  // latched, pwm ignored
        add(1, 1, 0, 0, 0, 0,  0, 0, 1);
        add(0, 1, 0, 0, 0, 0,  0, 0, 0);  // disable clears latch
        add(1, 1, 0, 0, 3, 2,  0, 0, 0);  // resume through DT_LH
        add(1, 1, 0, 0, 3, 2,  0, 0, 0);
        add(1, 1, 0, 0, 3, 2,  0, 0, 0);
        add(1, 1, 0, 0, 3, 2,  1, 0, 0);
        add(1, 0, 0, 0, 5, 2,  0, 0, 0);
        add(1, 0, 0, 0, 5, 2,  0, 0, 0);
        add(1, 0, 0, 0, 5, 2,  0, 1, 0);
        add(1, 1, 0, 0, 5, 2,  0, 0, 0);  // DT_LH with 5 cycles
        add(1, 1, 0, 0, 5, 2,  0, 0, 0);
        add(1, 0, 0, 0, 5, 2,  0, 0, 0);  // abort to DT_HL
        add(1, 0, 0, 0, 5, 2,  0, 0, 0);
        add(1, 0, 0, 0, 5, 2,  0, 1, 0);  // ls after dt_hl, hs never asserted
        add(1, 1, 0, 0, 4, 2,  0, 0, 0);  // load 4
        add(1, 1, 0, 0, 1, 2,  0, 0, 0);  // mid-dead-time change ignored
        add(1, 1, 0, 0, 1, 2,  0, 0, 0);
        add(1, 1, 0, 0, 1, 2,  0, 0, 0);
        add(1, 1, 0, 0, 1, 2,  1, 0, 0);
        add(0, 1, 0, 0, 1, 2,  0, 0, 0);  // disable -> OFF in one edge

        rst_n = 1'b0;
        en = 1'b0; pwm = 1'b0; zcd = 1'b0; flt = 1'b0;
        dt_lh = '0; dt_hl = '0;
        repeat (3) @(posedge clk);
        #1;
        check("reset hs_o", hs_o, 1'b0);
        check("reset ls_o", ls_o, 1'b0);
        check("reset flt_lat", flt_lat, 1'b0);
        rst_n = 1'b1;

        foreach (vecs[i]) begin
            en = vecs[i].en; pwm = vecs[i].pwm; zcd = vecs[i].zcd; flt = vecs[i].flt;
            dt_lh = vecs[i].lh; dt_hl = vecs[i].hl;
            sb.push_back('{hs: vecs[i].hs, ls: vecs[i].ls, fl: vecs[i].fl});
            @(posedge clk);
            #1;
            e = sb.pop_front();
            check($sformatf("vec%0d hs_o", i), hs_o, e.hs);
            check($sformatf("vec%0d ls_o", i), ls_o, e.ls);
            check($sformatf("vec%0d flt_lat", i), flt_lat, e.fl);
            check($sformatf("vec%0d overlap", i), hs_o & ls_o, 1'b0);
        end

        // Short pwm pulse: high side width depends on the minimum on-time build.
        en = 1'b1; pwm = 1'b0; zcd = 1'b0; flt = 1'b0; dt_lh = DTW'(1); dt_hl = DTW'(2);
        @(posedge clk);
        #1;
        hs_cnt = 0;
        pwm = 1'b1;
        repeat (3) begin
            @(posedge clk);
            #1;
            if (hs_o) hs_cnt++;
        end
        pwm = 1'b0;
        repeat (30) begin
            @(posedge clk);
            #1;
            if (hs_o) hs_cnt++;
            if (hs_o & ls_o) check("minon overlap", hs_o & ls_o, 1'b0);
        end
        check("minon hs width", hs_cnt, EXP_HS_WIDTH);
        check("minon ends in LS_ON", ls_o, 1'b1);

        // Asynchronous reset in HS_ON.
        pwm = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("pre-reset hs_o", hs_o, 1'b1);
        #2;
        rst_n = 1'b0;
        #1;
        check("async reset hs_o", hs_o, 1'b0);
        check("async reset ls_o", ls_o, 1'b0);
        @(posedge clk);
        #1;
        check("held reset hs_o", hs_o, 1'b0);
        rst_n = 1'b1;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
